alu_cmd_issuer: RTL

Command-side driver for the arithmetic logic unit. Accepts one operation request at a time over a valid/ready command port. Drives the ALU's op and operand inputs, waits a fixed ALU latency, then captures the ALU result and status. Returns them on a valid/ready response port, and keeps running counts of completed operations and of responses flagging A < B (status bit 0).

---
 rtl/alu_cmd_issuer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Command-side driver for an ALU. It accepts one request at a time on a
// valid/ready command port and drives the ALU op and operand registers. It
// then waits LAT+1 cycles, captures the ALU result and status, and presents
// them on a valid/ready response port. It also keeps wrapping counts of
// completed responses and of responses whose status bit 0 (A < B) is set.
//
// Ports
//   i_clk, i_reset      clock (rising edge), synchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_op/a/b     command handshake and payload
//   o_alu_op/o_alu_arg_A/o_alu_arg_B          registered ALU inputs
//   i_alu_result/i_alu_status                 ALU outputs, sampled after LAT
//   o_rsp_valid/i_rsp_ready, o_rsp_op/result/status  response handshake
//   o_done_count/o_less_count                 response statistics
module alu_cmd_issuer #(
  parameter int N     = 2,
  parameter int M     = 8,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [N-1:0]     i_cmd_op,
  input  logic [M-1:0]     i_cmd_a,
  input  logic [M-1:0]     i_cmd_b,
  output logic [N-1:0]     o_alu_op,
  output logic [M-1:0]     o_alu_arg_A,
  output logic [M-1:0]     o_alu_arg_B,
  input  logic [M-1:0]     i_alu_result,
  input  logic [3:0]       i_alu_status,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [N-1:0]     o_rsp_op,
  output logic [M-1:0]     o_rsp_result,
  output logic [3:0]       o_rsp_status,
  output logic [CNT_W-1:0] o_done_count,
  output logic [CNT_W-1:0] o_less_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]       LAT_L   = 4'(LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_capture;
  logic             w_hs;
  logic [3:0]       r_wait;
  logic [N-1:0]     r_alu_op;
  logic [M-1:0]     r_alu_a;
  logic [M-1:0]     r_alu_b;
  logic [N-1:0]     r_rsp_op;
  logic [M-1:0]     r_rsp_result;
  logic [3:0]       r_rsp_status;
  logic [CNT_W-1:0] r_done;
  logic [CNT_W-1:0] r_less;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_hs      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        // The counter is loaded with LAT on accept and runs down to zero,
        // so the state lasts LAT+1 cycles and captures on the last one.
        if (r_wait == '0) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_hs   = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wait       <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_op     <= '0;
      r_rsp_result <= '0;
      r_rsp_status <= '0;
      r_done       <= '0;
      r_less       <= '0;
    end else begin
      if (w_accept) begin
        r_alu_op <= i_cmd_op;
        r_alu_a  <= i_cmd_a;
        r_alu_b  <= i_cmd_b;
        r_wait   <= LAT_L;
      end
      if (r_state == WAIT && r_wait != '0) begin
        r_wait <= r_wait - 4'd1;
      end
      if (w_capture) begin
        r_rsp_result <= i_alu_result;
        r_rsp_status <= i_alu_status;
        r_rsp_op     <= r_alu_op;
      end
      if (w_hs) begin
        r_done <= r_done + CNT_ONE;
        if (r_rsp_status[0]) begin
          r_less <= r_less + CNT_ONE;
        end
      end
    end
  end

  assign o_cmd_ready  = (r_state == IDLE);
  assign o_rsp_valid  = (r_state == RESP);
  assign o_alu_op     = r_alu_op;
  assign o_alu_arg_A  = r_alu_a;
  assign o_alu_arg_B  = r_alu_b;
  assign o_rsp_op     = r_rsp_op;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_status = r_rsp_status;
  assign o_done_count = r_done;
  assign o_less_count = r_less;

endmodule
